// File: rtl/bn_pkg.sv
// Shared encodings for the batch-normalization feeder: parameter-table selects,
// sequencer states and IEEE-754 constants.
package bn_pkg;

  localparam logic [1:0] BN_SEL_GAMMA = 2'd0;
  localparam logic [1:0] BN_SEL_BETA  = 2'd1;
  localparam logic [1:0] BN_SEL_MEAN  = 2'd2;
  localparam logic [1:0] BN_SEL_DENOM = 2'd3;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bn_state_e;

  // Index width that stays legal for single-entry tables.
  function automatic int unsigned bn_clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bn_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count; storage is reset so
// the head reads zero after reset.
module bn_result_fifo
  import bn_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = bn_clog2_min1(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop && (count != '0);
  assign rdata  = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_next(rd_ptr);
      // Push and pop together leave the count unchanged.
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/batch_normalization_feeder.sv
// Sequencer for one free-running batch-normalization element: per-channel tables,
// credit-based feature intake, result FIFO. Define BN_RELU_EN to clamp negative results to zero.
module batch_normalization_feeder
  import bn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_CHANNELS = 64,
  parameter int unsigned SPATIAL_SIZE = 16,
  parameter int unsigned ELEM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned CH_W = bn_clog2_min1(NUM_CHANNELS),
  localparam int unsigned SP_W = bn_clog2_min1(SPATIAL_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  param_we_i,
  input  logic [1:0]            param_sel_i,
  input  logic [CH_W-1:0]       param_addr_i,
  input  logic [DATA_WIDTH-1:0] param_data_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [DATA_WIDTH-1:0] elem_data_o,
  output logic [DATA_WIDTH-1:0] elem_gamma_o,
  output logic [DATA_WIDTH-1:0] elem_beta_o,
  output logic [DATA_WIDTH-1:0] elem_mean_o,
  output logic [DATA_WIDTH-1:0] elem_denom_o,
  input  logic [DATA_WIDTH-1:0] elem_result_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  frame_done_o,
  output logic                  param_err_o
);

  localparam int unsigned PIPE_W = ELEM_LATENCY + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W  = $clog2(FIFO_DEPTH + ELEM_LATENCY + 2);

  bn_state_e             state;
  logic [CH_W-1:0]       ch_cnt;
  logic [SP_W-1:0]       sp_cnt;
  logic [PIPE_W-1:0]     vpipe;
  logic [PIPE_W-1:0]     lpipe;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [SUM_W-1:0]      inflight;
  logic                  credit_ok;
  logic                  accept;
  logic                  sp_wrap;
  logic                  ch_wrap;
  logic                  last_elem;
  logic                  fifo_push;
  logic                  fifo_pop;

  logic [DATA_WIDTH-1:0] gamma_tab [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] beta_tab  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] mean_tab  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] denom_tab [NUM_CHANNELS];

  // Results still inside the element count against FIFO space, so a push always fits.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(PIPE_W); i++) inflight = inflight + SUM_W'(vpipe[i]);
  end

  assign credit_ok    = (SUM_W'(fifo_count) + inflight) < SUM_W'(FIFO_DEPTH);
  assign data_ready_o = (state == ST_RUN) && credit_ok;
  assign accept       = data_valid_i && data_ready_o;
  assign sp_wrap      = (sp_cnt == SP_W'(SPATIAL_SIZE - 1));
  assign ch_wrap      = (ch_cnt == CH_W'(NUM_CHANNELS - 1));
  assign last_elem    = sp_wrap && ch_wrap;
  assign fifo_push    = vpipe[PIPE_W-1];
  assign fifo_pop     = out_ready_i && out_valid_o;

  // Tables are intentionally not reset; they survive a mid-frame reset.
  always_ff @(posedge clk) begin
    if (param_we_i && (state == ST_IDLE)) begin
      case (param_sel_i)
        BN_SEL_GAMMA: gamma_tab[param_addr_i] <= param_data_i;
        BN_SEL_BETA:  beta_tab[param_addr_i]  <= param_data_i;
        BN_SEL_MEAN:  mean_tab[param_addr_i]  <= param_data_i;
        BN_SEL_DENOM: denom_tab[param_addr_i] <= param_data_i;
        default:      ;
      endcase
    end
  end

  // Frame sequencer, position counters, element operand registers and tap pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      ch_cnt       <= '0;
      sp_cnt       <= '0;
      vpipe        <= '0;
      lpipe        <= '0;
      elem_data_o  <= '0;
      elem_gamma_o <= '0;
      elem_beta_o  <= '0;
      elem_mean_o  <= '0;
      elem_denom_o <= '0;
      frame_done_o <= 1'b0;
      param_err_o  <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      vpipe        <= {vpipe[PIPE_W-2:0], accept};
      lpipe        <= {lpipe[PIPE_W-2:0], accept && last_elem};

      if (accept) begin
        elem_data_o  <= data_i;
        elem_gamma_o <= gamma_tab[ch_cnt];
        elem_beta_o  <= beta_tab[ch_cnt];
        elem_mean_o  <= mean_tab[ch_cnt];
        elem_denom_o <= denom_tab[ch_cnt];
        if (sp_wrap) begin
          sp_cnt <= '0;
          ch_cnt <= ch_wrap ? '0 : ch_cnt + CH_W'(1);
        end else begin
          sp_cnt <= sp_cnt + SP_W'(1);
        end
      end

      if (param_we_i && (state != ST_IDLE)) param_err_o <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state       <= ST_RUN;
            ch_cnt      <= '0;
            sp_cnt      <= '0;
            param_err_o <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept && last_elem) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((vpipe == '0) && (fifo_count == '0)) begin
            state        <= ST_DONE;
            frame_done_o <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  bn_result_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   ({lpipe[PIPE_W-1], elem_result_i}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .count   (fifo_count)
  );

  assign out_valid_o = (fifo_count != '0);
  assign out_last_o  = fifo_rdata[DATA_WIDTH];

`ifdef BN_RELU_EN
  // Any set sign bit, including negative zero, is clamped.
  assign out_data_o = fifo_rdata[DATA_WIDTH-1] ? DATA_WIDTH'(FP_ZERO)
                                               : fifo_rdata[DATA_WIDTH-1:0];
`else
  assign out_data_o = fifo_rdata[DATA_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_batch_normalization_feeder.sv
// Randomized bench for batch_normalization_feeder with a behavioural BN element
// and a stream-level reference of the expected output sequence.
module tb_batch_normalization_feeder;
  import bn_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned NC    = 64;
  localparam int unsigned SS    = 16;
  localparam int unsigned EL    = 2;
  localparam int unsigned FD    = 4;
  localparam int          FRAME = NC * SS;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          start_i;
  logic          param_we_i;
  logic [1:0]    param_sel_i;
  logic [5:0]    param_addr_i;
  logic [DW-1:0] param_data_i;
  logic [DW-1:0] data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic [DW-1:0] elem_data_o, elem_gamma_o, elem_beta_o, elem_mean_o, elem_denom_o;
  logic [DW-1:0] elem_result_i;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_last_o;
  logic          out_ready_i;
  logic          frame_done_o;
  logic          param_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int last_cnt = 0;
  int frames   = 0;
  int acc_cnt  = 0;
  int ready_mode = 2;
  bit feed_done = 1'b1;
  bit abort     = 1'b0;
  bit in_frame  = 1'b0;
  exp_t exp_q[$];

  logic [31:0] t_gamma [NC];
  logic [31:0] t_beta  [NC];
  logic [31:0] t_mean  [NC];
  logic [31:0] t_denom [NC];

  batch_normalization_feeder #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .SPATIAL_SIZE(SS),
    .ELEM_LATENCY(EL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .param_we_i(param_we_i), .param_sel_i(param_sel_i),
    .param_addr_i(param_addr_i), .param_data_i(param_data_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .elem_data_o(elem_data_o), .elem_gamma_o(elem_gamma_o), .elem_beta_o(elem_beta_o),
    .elem_mean_o(elem_mean_o), .elem_denom_o(elem_denom_o),
    .elem_result_i(elem_result_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .frame_done_o(frame_done_o), .param_err_o(param_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Float <-> real, normal numbers only; tiny results flush to signed zero.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
    e = {3'd0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] <= 11'd896) return {d[63], 31'd0};
    if (d[62:52] >= 11'd1151) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] bn_fn(input logic [31:0] x, g, b, m, d);
    return r2f(f2r(g) * (f2r(x) - f2r(m)) / f2r(d) + f2r(b));
  endfunction

  function automatic logic [31:0] relu_ref(input logic [31:0] x);
`ifdef BN_RELU_EN
    return x[31] ? FP_ZERO : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] small_int_fp(input int lo, input int hi);
    int v;
    v = lo + int'($urandom_range(0, hi - lo));
    return r2f(real'(v));
  endfunction

  function automatic logic [31:0] gen_data(input int kind);
    case (kind)
      0:       return 32'h4000_0000;
      2:       return 32'hBF80_0000;
      default: begin
        if ($urandom_range(0, 15) == 0) return 32'h8000_0000;
        return small_int_fp(-8, 8);
      end
    endcase
  endfunction

  // Behavioural element: two register stages from operands to result.
  logic [31:0] el1 = '0;
  logic [31:0] el2 = '0;
  initial forever begin
    @(posedge clk);
    el1 <= bn_fn(elem_data_o, elem_gamma_o, elem_beta_o, elem_mean_o, elem_denom_o);
    el2 <= el1;
  end
  assign elem_result_i = el2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready_i = 1'b0;
        1:       out_ready_i = 1'b1;
        default: out_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: every pop is compared against the reference stream.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n) begin
      if (frame_done_o) done_cnt++;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data_o, e.data);
          chk("out_last", {31'd0, out_last_o}, {31'd0, e.last});
          if (out_last_o) last_cnt++;
        end
      end
    end
  end

  task automatic write_param(input logic [1:0] sel, input int addr, input logic [31:0] d);
    param_we_i   = 1'b1;
    param_sel_i  = sel;
    param_addr_i = 6'(addr);
    param_data_i = d;
    @(posedge clk); #1;
    param_we_i = 1'b0;
    if (!in_frame) begin
      case (sel)
        BN_SEL_GAMMA: t_gamma[addr] = d;
        BN_SEL_BETA:  t_beta[addr]  = d;
        BN_SEL_MEAN:  t_mean[addr]  = d;
        default:      t_denom[addr] = d;
      endcase
    end
  endtask

  task automatic load_tables(input int kind);
    for (int c = 0; c < NC; c++) begin
      if (kind == 0) begin
        write_param(BN_SEL_GAMMA, c, FP_ONE);
        write_param(BN_SEL_BETA,  c, FP_ZERO);
        write_param(BN_SEL_MEAN,  c, FP_ZERO);
        write_param(BN_SEL_DENOM, c, FP_ONE);
      end else begin
        case ($urandom_range(0, 3))
          0:       write_param(BN_SEL_GAMMA, c, 32'h3F00_0000);
          1:       write_param(BN_SEL_GAMMA, c, FP_ONE);
          2:       write_param(BN_SEL_GAMMA, c, 32'h4000_0000);
          default: write_param(BN_SEL_GAMMA, c, 32'hBF80_0000);
        endcase
        write_param(BN_SEL_BETA, c, small_int_fp(-4, 4));
        write_param(BN_SEL_MEAN, c, small_int_fp(-4, 4));
        case ($urandom_range(0, 2))
          0:       write_param(BN_SEL_DENOM, c, FP_ONE);
          1:       write_param(BN_SEL_DENOM, c, 32'h4000_0000);
          default: write_param(BN_SEL_DENOM, c, 32'h4080_0000);
        endcase
      end
    end
  endtask

  // Presents one channel-major frame with random valid gaps; each handshake
  // appends the normalised value of that element to the reference stream.
  task automatic feed_frame(input int kind);
    int   idx;
    int   ch;
    bit   hs;
    exp_t e;
    feed_done = 1'b0;
    acc_cnt   = 0;
    idx       = 0;
    start_i   = 1'b1;
    in_frame  = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (idx < FRAME && !abort) begin
      if (!data_valid_i && $urandom_range(0, 3) != 0) begin
        data_i       = gen_data(kind);
        data_valid_i = 1'b1;
      end
      @(negedge clk);
      hs = data_valid_i && data_ready_o;
      if (hs) begin
        ch     = idx / SS;
        e.data = relu_ref(bn_fn(data_i, t_gamma[ch], t_beta[ch], t_mean[ch], t_denom[ch]));
        e.last = (idx == FRAME - 1);
        exp_q.push_back(e);
        idx++;
        acc_cnt++;
      end
      @(posedge clk); #1;
      if (hs) data_valid_i = 1'b0;
    end
    data_valid_i = 1'b0;
    feed_done    = 1'b1;
  endtask

  task automatic finish_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done_o) seen = 1'b1;
    end
    chk("frame_done_seen", {31'd0, seen}, 32'd1);
    if (!seen) report();
    chk("queue_empty_at_done", exp_q.size(), 32'd0);
    chk("feed_complete", {31'd0, feed_done}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, frame_done_o}, 32'd0);
    chk("idle_not_ready", {31'd0, data_ready_o}, 32'd0);
    frames++;
    chk("done_pulse_count", done_cnt, frames);
    chk("last_count", last_cnt, frames);
    in_frame = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    start_i      = 1'b0;
    param_we_i   = 1'b0;
    param_sel_i  = '0;
    param_addr_i = '0;
    param_data_i = '0;
    data_i       = '0;
    data_valid_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  {31'd0, out_valid_o},  32'd0);
    chk("rst_out_data",   out_data_o,            32'd0);
    chk("rst_out_last",   {31'd0, out_last_o},   32'd0);
    chk("rst_ready",      {31'd0, data_ready_o}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
    chk("rst_param_err",  {31'd0, param_err_o},  32'd0);
    chk("rst_elem_gamma", elem_gamma_o,          32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Identity tables, data 2.0 everywhere, random downstream stalls.
    load_tables(0);
    ready_mode = 2;
    fork feed_frame(0); join_none
    finish_frame();

    // Channel 5 gets its own mean and beta.
    write_param(BN_SEL_MEAN, 5, FP_ONE);
    write_param(BN_SEL_BETA, 5, 32'h4040_0000);
    ready_mode = 1;
    fork feed_frame(0); join_none
    finish_frame();

    // Downstream stalled: intake must stop at the FIFO depth; a table write now is refused.
    ready_mode = 0;
    fork feed_frame(1); join_none
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("bp_accepts",     acc_cnt,               FD);
    chk("bp_ready_low",   {31'd0, data_ready_o}, 32'd0);
    chk("bp_out_valid",   {31'd0, out_valid_o},  32'd1);
    @(posedge clk); #1;
    write_param(BN_SEL_GAMMA, 0, 32'h4040_0000);
    @(negedge clk);
    chk("perr_set", {31'd0, param_err_o}, 32'd1);
    @(posedge clk); #1;
    ready_mode = 2;
    finish_frame();
    chk("perr_sticky", {31'd0, param_err_o}, 32'd1);

    // Random tables and data; starting the frame clears the sticky error.
    load_tables(1);
    fork feed_frame(1); join_none
    @(posedge clk);
    @(negedge clk);
    chk("perr_clear", {31'd0, param_err_o}, 32'd0);
    @(posedge clk); #1;
    finish_frame();

    // Reset in the middle of a stalled frame.
    ready_mode = 0;
    fork feed_frame(1); join_none
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
    @(posedge clk); #1;
    abort   = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid_o},  32'd0);
    chk("midrst_out_data",  out_data_o,            32'd0);
    chk("midrst_out_last",  {31'd0, out_last_o},   32'd0);
    chk("midrst_ready",     {31'd0, data_ready_o}, 32'd0);
    chk("midrst_elem_data", elem_data_o,           32'd0);
    for (int i = 0; i < 10 && !feed_done; i++) @(posedge clk);
    exp_q.delete();
    in_frame = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    abort   = 1'b0;
    @(posedge clk); #1;

    // Tables survive the reset.
    ready_mode = 2;
    fork feed_frame(1); join_none
    finish_frame();

    // Identity with -1.0 data; IDLE writes leave the error flag clear.
    load_tables(0);
    chk("idle_write_no_err", {31'd0, param_err_o}, 32'd0);
    ready_mode = 1;
    fork feed_frame(2); join_none
    finish_frame();

    report();
  end

endmodule
